load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; word width fixed at 32 bits, byte lanes little-endian.
REQ-002 clk  input  1  single clock; every register updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  1  CPU access request; sampled only in IDLE.
REQ-005 we  input  1  1 = store, 0 = load.
REQ-006 size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-007 sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  store data, right-justified.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  one-cycle pulse coincident with done on a rejected access.
REQ-013 rdata  output  32  load result, held until the next successful load.
REQ-014 MemRead  output  1  word read strobe to data memory.
REQ-015 MemWrite  output  1  word write strobe; memory writes on the clk edge ending the cycle.
REQ-016 Address  output  32  word-aligned memory address {addr[31:2],2'b00}.
REQ-017 WriteData  output  32  full word to write.
REQ-018 ReadData  input  32  memory read data, combinational from Address while MemRead=1.

Function
REQ-019 FSM states: IDLE, RD, RMW_RD, WR, RESP.
REQ-020 IDLE with req=1: latch addr, we, size, sign_ext, wdata. Next state: RESP with err pending if misaligned. Otherwise RD for loads, WR for word stores, RMW_RD for byte/halfword stores.
REQ-021 Misaligned: size=01 with addr[0]=1; size=10 with addr[1:0]!=0; size=11 always. None of these generates a memory access.
REQ-022 RD: MemRead=1. Register the extracted, extended value into rdata. Next state RESP.
REQ-023 RMW_RD: MemRead=1. Register ReadData into an internal merge word. Next state WR.
REQ-024 WR: MemWrite=1. WriteData = wdata for word stores. For sub-word stores, WriteData = the merge word with the target lane replaced. Next state RESP.
REQ-025 Byte lane k=addr[1:0] occupies bits [8k+7:8k]. Halfword h=addr[1] occupies bits [16h+15:16h]. Store lanes take wdata[7:0] or wdata[15:0].
REQ-026 Load extension: bit 7 or bit 15 of the extracted value is replicated when sign_ext=1; zeros are used otherwise. A word load passes through unchanged.
REQ-027 RESP: done=1, err=1 only for a rejected access. Next state IDLE unconditionally.
REQ-028 Latency from the req edge to the done cycle: load 2 cycles, word store 2, sub-word store 3, rejected access 1.
REQ-029 A req arriving while busy=1 is ignored and not queued. A req held high in the RESP cycle is not accepted; it is accepted in the following IDLE cycle.
REQ-030 MemRead and MemWrite are never simultaneously high. Both are 0 in IDLE and RESP.
REQ-031 Address is 0 unless MemRead or MemWrite is high. WriteData is 0 unless MemWrite is high.
REQ-032 rdata is unchanged by stores and by rejected accesses.

Reset
REQ-033 rst_n=0 forces state IDLE immediately. It also clears busy, done, err, rdata, MemRead, MemWrite, Address, WriteData and all latched registers to 0.
REQ-034 Reset asserted mid-operation (RD, RMW_RD or WR) aborts the operation: MemWrite drops asynchronously, no done pulse follows, and the block is in IDLE after release.
REQ-035 After rst_n rises, the first req is accepted on the first clk edge.

Verification
REQ-036 Memory word 0x10 = 0x8899AABB; load byte, addr=0x11, sign_ext=1 -> one RD cycle with Address=0x10; done 2 cycles after req; rdata=0xFFFFFFAA.
REQ-037 Same word; load halfword, addr=0x12, sign_ext=0 -> rdata=0x00008899.
REQ-038 Word 0x20 = 0x11223344; store byte, addr=0x23, wdata=0x000000EE -> RMW_RD then WR with WriteData=0xEE223344; done 3 cycles after req.
REQ-039 Store word, addr=0x06 -> no MemRead/MemWrite; done=err=1 one cycle after req; rdata unchanged.
REQ-040 Load issued, second req during RD; then rst_n pulsed low during a later WR cycle -> second req ignored; MemWrite low immediately on reset; busy=0 and no done after release.
REQ-041 Back-to-back: req held high continuously across two word loads -> second access begins only after RESP, with exactly one done per access.

Source files
------------

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Sits between a CPU and a word-wide data memory. It turns byte, halfword and
//   word loads and stores into aligned 32-bit memory accesses. Little-endian
//   byte lanes are used throughout.
//   - A sub-word load reads the whole word, picks out the addressed lane and
//     then sign- or zero-extends it.
//   - A sub-word store is a read-modify-write: the word is read, the target
//     lane is replaced, and the result is written back.
//   - A misaligned access, or one with the reserved size, never touches
//     memory. It completes with err in the response cycle.
//
// Ports
//   clk        single clock, rising-edge
//   rst_n      asynchronous active-low reset
//   req        access request, sampled only while idle
//   we         1 = store, 0 = load
//   size       00 byte, 01 halfword, 10 word, 11 reserved (always rejected)
//   sign_ext   loads: 1 = sign-extend, 0 = zero-extend
//   addr       byte address
//   wdata      store data, right-justified
//   busy       high whenever an access is in flight
//   done       one-cycle completion pulse
//   err        one-cycle pulse with done for a rejected access
//   rdata      last successful load result
//   MemRead    word read strobe
//   MemWrite   word write strobe (memory writes at the edge ending the cycle)
//   Address    word-aligned memory address, 0 when no strobe is active
//   WriteData  word to write, 0 when MemWrite is low
//   ReadData   combinational memory read data
// -----------------------------------------------------------------------------
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } stateT;

  stateT       stateReg, stateNext;

  logic [31:0] addrReg;
  logic        weReg;
  logic [1:0]  sizeReg;
  logic        signExtReg;
  logic [31:0] wdataReg;
  logic        errReg;
  logic [31:0] mergeReg;
  logic [31:0] rdataReg;

  logic        misaligned;
  logic [31:0] shiftedWord;
  logic [31:0] loadValue;
  logic [3:0]  laneHit;
  logic [31:0] mergedWord;

  // Alignment check on the live request inputs. The result decides the
  // state that follows IDLE.
  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Move the addressed lane down to bit 0. Halfwords are aligned, so the
  // shift is always 0 or 16 for them.
  assign shiftedWord = ReadData >> {addrReg[1:0], 3'b000};

  always_comb begin
    loadValue = ReadData;
    case (sizeReg)
      2'b00:   loadValue = {{24{signExtReg & shiftedWord[7]}},  shiftedWord[7:0]};
      2'b01:   loadValue = {{16{signExtReg & shiftedWord[15]}}, shiftedWord[15:0]};
      default: loadValue = ReadData;
    endcase
  end

  // Per-lane store merge. A word store hits every lane, so the merge word
  // has no effect in that case.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gLane
      localparam logic [1:0] LANE = gi;
      logic [7:0] laneByte;

      assign laneHit[gi] = (sizeReg == 2'b10) ||
                           ((sizeReg == 2'b01) && (addrReg[1] == LANE[1])) ||
                           ((sizeReg == 2'b00) && (addrReg[1:0] == LANE));

      always_comb begin
        laneByte = wdataReg[8*gi +: 8];
        if (sizeReg == 2'b00)
          laneByte = wdataReg[7:0];
        else if (sizeReg == 2'b01)
          laneByte = LANE[0] ? wdataReg[15:8] : wdataReg[7:0];
      end

      assign mergedWord[8*gi +: 8] = laneHit[gi] ? laneByte : mergeReg[8*gi +: 8];
    end
  endgenerate

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= IDLE;
      addrReg    <= '0;
      weReg      <= 1'b0;
      sizeReg    <= 2'b00;
      signExtReg <= 1'b0;
      wdataReg   <= '0;
      errReg     <= 1'b0;
      mergeReg   <= '0;
      rdataReg   <= '0;
    end else begin
      stateReg <= stateNext;
      if (stateReg == IDLE && req) begin
        addrReg    <= addr;
        weReg      <= we;
        sizeReg    <= size;
        signExtReg <= sign_ext;
        wdataReg   <= wdata;
        errReg     <= misaligned;
      end
      if (stateReg == RD && !weReg)
        rdataReg <= loadValue;
      if (stateReg == RMW_RD)
        mergeReg <= ReadData;
    end
  end

  // Next state and outputs. The outputs are decoded from the state register
  // only, so an asynchronous reset drops the strobes at once.
  always_comb begin
    stateNext = stateReg;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;
    case (stateReg)
      IDLE: begin
        busy = 1'b0;
        if (req) begin
          if (misaligned)
            stateNext = RESP;
          else if (!we)
            stateNext = RD;
          else if (size == 2'b10)
            stateNext = WR;
          else
            stateNext = RMW_RD;
        end
      end
      RD: begin
        MemRead   = 1'b1;
        Address   = {addrReg[31:2], 2'b00};
        stateNext = RESP;
      end
      RMW_RD: begin
        MemRead   = 1'b1;
        Address   = {addrReg[31:2], 2'b00};
        stateNext = WR;
      end
      WR: begin
        MemWrite  = 1'b1;
        Address   = {addrReg[31:2], 2'b00};
        WriteData = mergedWord;
        stateNext = RESP;
      end
      RESP: begin
        done      = 1'b1;
        err       = errReg;
        stateNext = IDLE;
      end
      default: begin
        busy      = 1'b0;
        stateNext = IDLE;
      end
    endcase
  end

  assign rdata = rdataReg;

endmodule
